lab2_proc_int_div_unit: RTL and testbench

- Iterative integer divide/remainder unit acting as a val/rdy responder for the 5-stage TinyRV2 pipeline.
- Handles the M-extension ops DIV, DIVU, REM and REMU.
- The X stage issues a request; the unit returns one 32-bit result through a response port.
- Uses a one-bit-per-cycle restoring algorithm: a multi-cycle counterpart to the single-cycle ALU.

---
 rtl/lab2_proc_int_div_unit.sv | 146 ++++++++++++++
 tb/tb_lab2_proc_int_div_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_int_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// The final cycle of CALC (counter == p_nbits) applies the sign fix-up and
// registers the result. Divide-by-zero parks the special result in the
// datapath and enters that same fix-up cycle directly.
module lab2_proc_int_div_unit #(
   parameter int unsigned p_nbits = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_val,
   output logic                   req_rdy,
   input  logic [2*p_nbits+1:0]   req_msg,
   output logic                   resp_val,
   input  logic                   resp_rdy,
   output logic [p_nbits-1:0]     resp_msg
);

   localparam int unsigned CW = $clog2(p_nbits) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [p_nbits-1:0]   dq_q, dq_d;
   logic [p_nbits-1:0]   rem_q, rem_d;
   logic [p_nbits-1:0]   div_q, div_d;
   logic                 is_rem_q, is_rem_d;
   logic                 neg_q, neg_d;
   logic                 req_rdy_q, req_rdy_d;
   logic                 resp_val_q, resp_val_d;
   logic [p_nbits-1:0]   resp_msg_q, resp_msg_d;

   logic [1:0]           fn;
   logic [p_nbits-1:0]   op_a, op_b;
   logic                 a_neg, b_neg;
   logic [p_nbits:0]     rem_sh;
   logic [p_nbits-1:0]   result;

   assign fn     = req_msg[2*p_nbits+1 -: 2];
   assign op_a   = req_msg[2*p_nbits-1 -: p_nbits];
   assign op_b   = req_msg[p_nbits-1:0];
   // fn[0]==0 selects the signed variants
   assign a_neg  = ~fn[0] & op_a[p_nbits-1];
   assign b_neg  = ~fn[0] & op_b[p_nbits-1];
   // one extra bit so a divisor above 2^(n-1) never loses the shifted-out MSB
   assign rem_sh = {rem_q, dq_q[p_nbits-1]};
   assign result = is_rem_q ? rem_q : dq_q;

   assign req_rdy  = req_rdy_q;
   assign resp_val = resp_val_q;
   assign resp_msg = resp_msg_q;

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dq_d       = dq_q;
      rem_d      = rem_q;
      div_d      = div_q;
      is_rem_d   = is_rem_q;
      neg_d      = neg_q;
      req_rdy_d  = req_rdy_q;
      resp_val_d = resp_val_q;
      resp_msg_d = resp_msg_q;

      case (state_q)
         IDLE: begin
            if (req_val) begin
               is_rem_d  = fn[1];
               div_d     = b_neg ? -op_b : op_b;
               state_d   = CALC;
               req_rdy_d = 1'b0;
               if (op_b != '0) begin
                  dq_d  = a_neg ? -op_a : op_a;
                  rem_d = '0;
                  neg_d = fn[1] ? a_neg : (a_neg ^ b_neg);
                  cnt_d = '0;
               end else begin
                  // quotient all ones, remainder = raw dividend, no sign fix-up
                  dq_d  = '1;
                  rem_d = op_a;
                  neg_d = 1'b0;
                  cnt_d = CW'(p_nbits);
               end
            end
         end
         CALC: begin
            if (cnt_q == CW'(p_nbits)) begin
               resp_msg_d = neg_q ? -result : result;
               resp_val_d = 1'b1;
               cnt_d      = '0;
               state_d    = DONE;
            end else begin
               if (rem_sh >= {1'b0, div_q}) begin
                  rem_d = rem_sh[p_nbits-1:0] - div_q;
                  dq_d  = {dq_q[p_nbits-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh[p_nbits-1:0];
                  dq_d  = {dq_q[p_nbits-2:0], 1'b0};
               end
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (resp_rdy) begin
               resp_val_d = 1'b0;
               req_rdy_d  = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            req_rdy_d  = 1'b1;
            resp_val_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dq_q       <= '0;
         rem_q      <= '0;
         div_q      <= '0;
         is_rem_q   <= 1'b0;
         neg_q      <= 1'b0;
         req_rdy_q  <= 1'b1;
         resp_val_q <= 1'b0;
         resp_msg_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dq_q       <= dq_d;
         rem_q      <= rem_d;
         div_q      <= div_d;
         is_rem_q   <= is_rem_d;
         neg_q      <= neg_d;
         req_rdy_q  <= req_rdy_d;
         resp_val_q <= resp_val_d;
         resp_msg_q <= resp_msg_d;
      end
   end

endmodule

// File: tb/tb_lab2_proc_int_div_unit.sv
// Testbench for lab2_proc_int_div_unit: vector table, latency, backpressure, reset.
module tb_lab2_proc_int_div_unit;

   localparam logic [1:0] F_DIV = 2'd0, F_DIVU = 2'd1, F_REM = 2'd2, F_REMU = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_val;
   logic        req_rdy;
   logic [65:0] req_msg;
   logic        resp_val;
   logic        resp_rdy;
   logic [31:0] resp_msg;

   int tests = 0;
   int fails = 0;
   logic [31:0] sb[$];

   typedef struct {
      string       name;
      logic [1:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   vec_t vecs[$];

   lab2_proc_int_div_unit #(.p_nbits(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_msg  (req_msg),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_msg (resp_msg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string name, input logic [1:0] fn, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
      vec_t v;
      v.name = name; v.fn = fn; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Response monitor: pops the scoreboard on every handoff
   always @(negedge clk) begin
      if (!reset && resp_val && resp_rdy) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got %h want no response", resp_msg);
         end else begin
            chk("resp_msg", resp_msg, sb.pop_front());
         end
      end
   end

   // Issue one request with resp_rdy high, check latency and return to idle
   task automatic issue(input string name, input logic [1:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
      int k;
      req_msg = {fn, a, b};
      req_val = 1'b1;
      k = 0;
      while (!req_rdy && k < 100) begin step(); k++; end
      if (!req_rdy) begin
         tests++; fails++;
         $display("FAIL %s accept_timeout: got req_rdy=0 want 1", name);
         req_val = 1'b0;
         return;
      end
      sb.push_back(exp);
      step();
      req_val = 1'b0;
      req_msg = {$urandom, $urandom, $urandom};
      k = 0;
      while (!resp_val && k < 100) begin step(); k++; end
      chk({name, "_latency"}, 32'(k), 32'(lat));
      step();
      chk({name, "_rdy_after"}, {31'd0, req_rdy}, 32'd1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      reset    = 1'b1;
      req_val  = 1'b0;
      req_msg  = '0;
      resp_rdy = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
      chk("rst_resp_val", {31'd0, resp_val}, 32'd0);
      chk("rst_resp_msg", resp_msg, 32'd0);

      add("divu_100_7",  F_DIVU, 32'd100,        32'd7,          32'd14,         33);
      add("remu_100_7",  F_REMU, 32'd100,        32'd7,          32'd2,          33);
      add("div_m7_2",    F_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33);
      add("rem_m7_2",    F_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33);
      add("rem_7_m2",    F_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          33);
      add("div_m7_m2",   F_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          33);
      add("rem_m7_m2",   F_REM,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF,   33);
      add("div_by0",     F_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1);
      add("divu_by0",    F_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1);
      add("rem_by0",     F_REM,  32'd5,          32'd0,          32'd5,          1);
      add("remu_by0",    F_REMU, 32'd5,          32'd0,          32'd5,          1);
      add("div_ovf",     F_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33);
      add("rem_ovf",     F_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          33);
      add("divu_ovf",    F_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33);
      add("remu_ovf",    F_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33);
      add("div_big",     F_DIV,  32'h12345678,   32'hFFFFFFF3,   32'hFE998332,   33);
      add("rem_big",     F_REM,  32'h12345678,   32'hFFFFFFF3,   32'd2,          33);
      add("divu_max",    F_DIVU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          33);
      add("remu_near",   F_REMU, 32'hFFFFFFFE,   32'hFFFFFFFF,   32'hFFFFFFFE,   33);
      add("remu_wide",   F_REMU, 32'h80000000,   32'h80000001,   32'h80000000,   33);
      add("div_min_2",   F_DIV,  32'h80000000,   32'd2,          32'hC0000000,   33);

      resp_rdy = 1'b1;
      for (int i = 0; i < vecs.size(); i++)
         issue(vecs[i].name, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      // Backpressure with a second request waiting
      resp_rdy = 1'b0;
      req_msg  = {F_DIVU, 32'd100, 32'd7};
      req_val  = 1'b1;
      sb.push_back(32'd14);
      step();
      req_msg = {F_REMU, 32'd100, 32'd7};
      k = 0;
      while (!resp_val && k < 100) begin step(); k++; end
      chk("bp_latency", 32'(k), 32'd33);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_resp_val", {31'd0, resp_val}, 32'd1);
         chk("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
         chk("bp_resp_msg", resp_msg, 32'd14);
      end
      resp_rdy = 1'b1;
      step();
      chk("bp_handoff_rdy", {31'd0, req_rdy}, 32'd1);
      chk("bp_handoff_val", {31'd0, resp_val}, 32'd0);
      sb.push_back(32'd2);
      step();
      req_val = 1'b0;
      chk("bp_next_accepted", {31'd0, req_rdy}, 32'd0);
      k = 0;
      while (!resp_val && k < 100) begin step(); k++; end
      chk("bp_next_latency", 32'(k), 32'd33);
      step();

      // Reset during CALC iteration 10 discards the operation
      req_msg = {F_DIVU, 32'd100, 32'd7};
      req_val = 1'b1;
      step();
      req_val = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
      chk("mid_rst_resp_val", {31'd0, resp_val}, 32'd0);
      for (int i = 0; i < 30; i++) step();
      chk("mid_rst_quiet", {31'd0, resp_val}, 32'd0);
      issue("divu_after_rst", F_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 33);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
